// File: rtl/aul_alu.sv
// rtl/aul_alu.sv - accumulator-style add/subtract unit with tri-state result bus
//
// Purpose:
//   Holds operand A in a register and adds or subtracts the bus operand b.
//   It captures the result in register G and drives G onto the shared bus
//   only while gout is high. The control FSM sequences ain/gin/gout one
//   cycle at a time. The unit has no sequencing of its own.
//
// Optional feature:
//   AUL_FLAGS_EN - when defined, a {Nf, Zf, Cf, Vf} flags register loads with
//                  G on gin and is exported on the flags port.
//
// Ports:
//   clk     in   system clock, rising-edge active
//   resetn  in   asynchronous active-low reset (clears A, G, flags)
//   a       in   N  operand source for the A register
//   b       in   N  second operand, sampled combinationally at the gin edge
//   addsub  in   0 = A + b, 1 = A - b
//   ain     in   load enable for A
//   gin     in   load enable for G (and flags)
//   gout    in   bus drive enable for G
//   ALUout  out  N  G when gout = 1, otherwise high-Z
//   flags   out  4  {Nf, Zf, Cf, Vf} (AUL_FLAGS_EN only)

module aul_alu #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         addsub,
  input  logic         ain,
  input  logic         gin,
  input  logic         gout,
  output logic [N-1:0] ALUout
`ifdef AUL_FLAGS_EN
  ,
  output logic [3:0]   flags
`endif
);

  logic [N-1:0] a_q, a_d;
  logic [N-1:0] g_q, g_d;
  logic [N-1:0] b_eff;
  logic [N-1:0] result;

  // Subtraction is done as A + ~b + 1, so the carry-in is addsub itself.
  assign b_eff = addsub ? ~b : b;

`ifdef AUL_FLAGS_EN
  logic [N:0]   sum;
  logic [3:0]   flags_q, flags_d;
  logic         nf, zf, cf, vf;

  assign sum    = {1'b0, a_q} + {1'b0, b_eff} + {{N{1'b0}}, addsub};
  assign result = sum[N-1:0];

  // Cf is the raw adder carry. For subtract this means "no borrow" (A >= b).
  assign nf = result[N-1];
  assign zf = (result == '0);
  assign cf = sum[N];
  // Overflow: both adder inputs share a sign and the result sign differs.
  assign vf = (a_q[N-1] == b_eff[N-1]) && (result[N-1] != a_q[N-1]);

  always_comb begin
    flags_d = flags_q;
    if (gin) begin
      flags_d = {nf, zf, cf, vf};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`else
  // The carry out is only needed for flags, so the adder is kept N bits wide here.
  assign result = a_q + b_eff + {{(N-1){1'b0}}, addsub};
`endif

  // When ain and gin are both set, G takes the sum formed from the old A,
  // because both registers update on the same edge.
  always_comb begin
    a_d = a_q;
    g_d = g_q;
    if (ain) begin
      a_d = a;
    end
    if (gin) begin
      g_d = result;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q <= '0;
      g_q <= '0;
    end else begin
      a_q <= a_d;
      g_q <= g_d;
    end
  end

  // The bus drive is purely combinational on gout.
  assign ALUout = gout ? g_q : {N{1'bz}};

endmodule

// File: tb/tb_aul_alu.sv
// tb/tb_aul_alu.sv - directed self-checking bench for aul_alu
module tb_aul_alu;

  logic       clk;
  logic       resetn;
  logic [7:0] a;
  logic [7:0] b;
  logic       addsub;
  logic       ain;
  logic       gin;
  logic       gout;
  tri1  [7:0] bus;
`ifdef AUL_FLAGS_EN
  logic [3:0] flags;
`endif

  int total;
  int bad;

  aul_alu #(.N(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .a      (a),
    .b      (b),
    .addsub (addsub),
    .ain    (ain),
    .gin    (gin),
    .gout   (gout),
    .ALUout (bus)
`ifdef AUL_FLAGS_EN
    ,
    .flags  (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp);
`ifdef AUL_FLAGS_EN
    check(tag, {4'h0, flags}, {4'h0, exp});
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic sub);
    gout = 1'b0;
    a = av; b = bv; addsub = sub;
    ain = 1'b1; step(); ain = 1'b0;
    gin = 1'b1; step(); gin = 1'b0;
    gout = 1'b1; #1;
  endtask

  initial begin
    total = 0; bad = 0;
    a = 8'h00; b = 8'h00; addsub = 1'b0;
    ain = 1'b0; gin = 1'b0; gout = 1'b1;
    resetn = 1'b0;
    #2;
    check("reset_drive", bus, 8'h00);
    check_flags("reset_flags", 4'b0000);
    gout = 1'b0; #1;
    check("reset_release_bus", bus, 8'hFF);
    step();
    resetn = 1'b1;
    step();

    run_op(8'h02, 8'h03, 1'b0);
    check("add", bus, 8'h05);
    check_flags("add_flags", 4'b0000);
    gout = 1'b0; #1;
    check("bus_release", bus, 8'hFF);

    run_op(8'h02, 8'h03, 1'b1);
    check("sub", bus, 8'hFF);
    check_flags("sub_flags", 4'b1000);

    run_op(8'h81, 8'h8F, 1'b0);
    check("ovf_add", bus, 8'h10);
    check_flags("ovf_flags", 4'b0011);

    gout = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = 8'h40 + 8'(i); addsub = i[0];
      step();
    end
    gout = 1'b1; #1;
    check("hold_g", bus, 8'h10);
    check_flags("hold_flags", 4'b0011);

    gout = 1'b0;
    a = 8'h02; ain = 1'b1; step();
    a = 8'h10; b = 8'h01; addsub = 1'b0; gin = 1'b1; step();
    ain = 1'b0; gin = 1'b0;
    gout = 1'b1; #1;
    check("ain_gin_g", bus, 8'h03);
    b = 8'h00; gin = 1'b1; step(); gin = 1'b0; #1;
    check("ain_gin_a", bus, 8'h10);

    b = 8'h05; addsub = 1'b0; gin = 1'b1; #1;
    check("gout_gin_old", bus, 8'h10);
    step(); gin = 1'b0; #1;
    check("gout_gin_new", bus, 8'h15);

    run_op(8'h02, 8'h03, 1'b0);
    check("pre_reset", bus, 8'h05);
    #2;
    resetn = 1'b0; #1;
    check("async_reset_bus", bus, 8'h00);
    check_flags("async_reset_flags", 4'b0000);
    #2;
    resetn = 1'b1;
    step();
    b = 8'h04; addsub = 1'b0; gin = 1'b1; step(); gin = 1'b0; #1;
    check("after_reset_g", bus, 8'h04);

    gout = 1'b0;
    a = 8'h33; ain = 1'b1; step(); ain = 1'b0;
    #2; resetn = 1'b0; #2; resetn = 1'b1;
    step();
    b = 8'h01; gin = 1'b1; step(); gin = 1'b0;
    gout = 1'b1; #1;
    check("reset_discards_a", bus, 8'h01);

    run_op(8'h7F, 8'h7F, 1'b1);
    check("sub_zero", bus, 8'h00);
    check_flags("sub_zero_flags", 4'b0110);

    run_op(8'hFF, 8'h01, 1'b0);
    check("add_wrap", bus, 8'h00);
    check_flags("add_wrap_flags", 4'b0110);

    run_op(8'h00, 8'h01, 1'b1);
    check("sub_wrap", bus, 8'hFF);
    check_flags("sub_wrap_flags", 4'b1000);

    run_op(8'h7F, 8'h01, 1'b0);
    check("pos_ovf", bus, 8'h80);
    check_flags("pos_ovf_flags", 4'b1001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
